// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the systolic feeder and PE array
package systolic_pkg;

   localparam int N_DEF  = 4;
   localparam int DW_DEF = 16;
   localparam int ACC_W  = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Lane l of a packed N*DW bus occupies [lane_lsb(l, dw) +: dw].
   function automatic int lane_lsb(input int lane, input int dw);
      return lane * dw;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - fixed-depth operand shift register with async active-low clear
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DEPTH-1:0][DW-1:0] stage;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage <= '0;
      end else begin
         stage[0] <= din;
         for (int s = 1; s < DEPTH; s++) begin
            stage[s] <= stage[s-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skews k-slices onto the array edges and sequences clear/flush/done
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N*DW-1:0] in_a,
   input  logic [N*DW-1:0] in_b,
   output logic [N*DW-1:0] out_W,
   output logic [N*DW-1:0] out_N,
   output logic          pe_clear,
   output logic          done,
   input  logic          done_ack
);

   localparam int CW = $clog2(2 * N);
   localparam logic [CW-1:0] FLUSH_LEN = CW'(2 * N - 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            accept;
   logic [N*DW-1:0] a_in, b_in;

   assign in_ready = (state == IDLE) || (state == FEED);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (N == 1) begin
                  state_nx = FLUSH;
                  cnt_nx   = FLUSH_LEN;
               end else begin
                  state_nx = FEED;
                  cnt_nx   = CW'(1);
               end
            end
         end
         FEED: begin
            if (accept) begin
               if (cnt == LAST_BEAT) begin
                  state_nx = FLUSH;
                  cnt_nx   = FLUSH_LEN;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
         end
         FLUSH: begin
            // 2N-1 flush edges let the last wavefront reach PE[N-1][N-1].
            if (cnt == CW'(1)) begin
               state_nx = DONE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         DONE: begin
            if (done_ack) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         pe_clear <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         pe_clear <= (state_nx == IDLE);
         done     <= (state_nx == DONE);
      end
   end

   // Unaccepted cycles inject a zero wavefront so stalls keep lanes aligned.
   assign a_in = accept ? in_a : '0;
   assign b_in = accept ? in_b : '0;

   for (genvar l = 0; l < N; l++) begin : g_lane
      skew_delay_line #(.DEPTH(l + 1), .DW(DW)) u_a_line (
         .clk  (clk),
         .reset(reset),
         .din  (a_in[lane_lsb(l, DW) +: DW]),
         .dout (out_W[lane_lsb(l, DW) +: DW])
      );
      skew_delay_line #(.DEPTH(l + 1), .DW(DW)) u_b_line (
         .clk  (clk),
         .reset(reset),
         .din  (b_in[lane_lsb(l, DW) +: DW]),
         .dout (out_N[lane_lsb(l, DW) +: DW])
      );
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder driving a 2x2 PE array model
module tb_systolic_feeder;
   import systolic_pkg::*;

   localparam int N  = 2;
   localparam int DW = 16;
   localparam int HW = 2048;

   typedef logic [N-1:0][N-1:0][DW-1:0]    mat_t;
   typedef logic [N-1:0][N-1:0][ACC_W-1:0] res_t;
   typedef struct {
      mat_t a;
      mat_t b;
      int   stall;
      int   ack_wait;
      bit   hold;
      bit   ack_valid;
      res_t exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic            done_ack = 1'b0;
   logic [N*DW-1:0] in_a = '0;
   logic [N*DW-1:0] in_b = '0;
   logic [N*DW-1:0] out_W, out_N;
   logic            in_ready, pe_clear, done;

   always #5 clk = ~clk;

   systolic_feeder #(.N(N), .DW(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a    (in_a),
      .in_b    (in_b),
      .out_W   (out_W),
      .out_N   (out_N),
      .pe_clear(pe_clear),
      .done    (done),
      .done_ack(done_ack)
   );

   int              total = 0;
   int              bad = 0;
   int              cyc;
   bit              take = 1'b0;
   logic [N*DW-1:0] hist_a [HW];
   logic [N*DW-1:0] hist_b [HW];
   logic [DW-1:0]   pa [N][N];
   logic [DW-1:0]   pb [N][N];
   logic [ACC_W-1:0] acc [N][N];
   vec_t            tv [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] col_a(input mat_t m, input int k);
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = m[i][k];
      return r;
   endfunction

   function automatic logic [N*DW-1:0] row_b(input mat_t m, input int k);
      logic [N*DW-1:0] r;
      for (int j = 0; j < N; j++) r[j*DW +: DW] = m[k][j];
      return r;
   endfunction

   function automatic mat_t mk(input int m00, input int m01, input int m10, input int m11);
      mat_t m;
      m[0][0] = DW'(m00); m[0][1] = DW'(m01);
      m[1][0] = DW'(m10); m[1][1] = DW'(m11);
      return m;
   endfunction

   function automatic res_t mkr(input int r00, input int r01, input int r10, input int r11);
      res_t r;
      r[0][0] = ACC_W'(r00); r[0][1] = ACC_W'(r01);
      r[1][0] = ACC_W'(r10); r[1][1] = ACC_W'(r11);
      return r;
   endfunction

   // One clock: advance the attached PE array, record what should have entered the lanes, check lanes.
   task automatic step();
      logic [N*DW-1:0] w, nb;
      logic            clr;
      logic [DW-1:0]   oa [N][N];
      logic [DW-1:0]   ob [N][N];
      logic [DW-1:0]   iw, inn;
      if (take) check("accept ready", in_ready, 1);
      w = out_W; nb = out_N; clr = pe_clear; oa = pa; ob = pb;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (j == 0) iw = w[i*DW +: DW];
            else        iw = oa[i][j-1];
            if (i == 0) inn = nb[j*DW +: DW];
            else        inn = ob[i-1][j];
            if (clr) begin
               acc[i][j] = '0; pa[i][j] = '0; pb[i][j] = '0;
            end else begin
               acc[i][j] = acc[i][j] + ACC_W'(iw) * ACC_W'(inn);
               pa[i][j] = iw; pb[i][j] = inn;
            end
         end
      end
      cyc++;
      hist_a[cyc % HW] = take ? in_a : '0;
      hist_b[cyc % HW] = take ? in_b : '0;
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("W lane%0d", i), out_W[i*DW +: DW], hist_a[(cyc - i) % HW][i*DW +: DW]);
         check($sformatf("N lane%0d", i), out_N[i*DW +: DW], hist_b[(cyc - i) % HW][i*DW +: DW]);
      end
   endtask

   task automatic run_job(input vec_t v);
      int lat;
      check("idle ready", in_ready, 1);
      check("idle clear", pe_clear, 1);
      check("idle done", done, 0);
      for (int k = 0; k < N; k++) begin
         if (k > 0) begin
            for (int s = 0; s < v.stall; s++) begin
               in_valid = 1'b0; take = 1'b0;
               in_a = $urandom; in_b = $urandom;
               done_ack = 1'($urandom_range(0, 1));
               step();
               check("stall ready", in_ready, 1);
            end
         end
         done_ack = 1'b0;
         in_valid = 1'b1; take = 1'b1;
         in_a = col_a(v.a, k); in_b = row_b(v.b, k);
         step();
         if (k == 0) check("clear drop", pe_clear, 0);
      end
      take = 1'b0; in_valid = v.hold; lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         check("flush ready", in_ready, 0);
         in_a = $urandom; in_b = $urandom;
         done_ack = 1'($urandom_range(0, 1));
         step();
         lat++;
      end
      done_ack = 1'b0;
      check("done latency", lat, 2 * N - 1);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            check($sformatf("C[%0d][%0d]", i, j), acc[i][j], v.exp[i][j]);
      for (int w = 1; w < v.ack_wait; w++) begin
         step();
         check("done hold", done, 1);
         check("done ready", in_ready, 0);
      end
      done_ack = 1'b1; in_valid = v.ack_valid;
      step();
      done_ack = 1'b0; in_valid = 1'b0;
      check("ack done", done, 0);
      check("ack clear", pe_clear, 1);
      check("ack ready", in_ready, 1);
   endtask

   initial begin
      vec_t rv;
      logic [ACC_W-1:0] sum;

      tv[0] = '{a: mk(1, 2, 3, 4), b: mk(5, 6, 7, 8), stall: 0, ack_wait: 0,
                hold: 1'b0, ack_valid: 1'b0, exp: mkr(19, 22, 43, 50)};
      tv[1] = '{a: mk(1, 2, 3, 4), b: mk(5, 6, 7, 8), stall: 3, ack_wait: 1,
                hold: 1'b0, ack_valid: 1'b0, exp: mkr(19, 22, 43, 50)};
      tv[2] = '{a: mk(1, 2, 3, 4), b: mk(5, 6, 7, 8), stall: 0, ack_wait: 5,
                hold: 1'b1, ack_valid: 1'b1, exp: mkr(19, 22, 43, 50)};
      tv[3] = '{a: mk(1, 0, 0, 1), b: mk(9, 8, 7, 6), stall: 0, ack_wait: 2,
                hold: 1'b0, ack_valid: 1'b0, exp: mkr(9, 8, 7, 6)};

      for (int k = 0; k < HW; k++) begin
         hist_a[k] = '0; hist_b[k] = '0;
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            pa[i][j] = '0; pb[i][j] = '0; acc[i][j] = '0;
         end
      cyc = N;

      repeat (2) @(posedge clk);
      #1;
      check("rst out_W", out_W, 0);
      check("rst out_N", out_N, 0);
      check("rst clear", pe_clear, 1);
      check("rst ready", in_ready, 1);
      check("rst done", done, 0);
      reset = 1'b1;

      // Reset mid-FEED while lane 1 is carrying a live operand.
      in_valid = 1'b1; take = 1'b1;
      in_a = col_a(tv[0].a, 0); in_b = row_b(tv[0].b, 0);
      step();
      in_valid = 1'b0; take = 1'b0;
      step();
      #2 reset = 1'b0;
      #1;
      check("midrst out_W", out_W, 0);
      check("midrst out_N", out_N, 0);
      check("midrst clear", pe_clear, 1);
      check("midrst ready", in_ready, 1);
      check("midrst done", done, 0);
      for (int k = 0; k < N; k++) begin
         hist_a[(cyc - k) % HW] = '0; hist_b[(cyc - k) % HW] = '0;
      end
      @(posedge clk);
      #1 reset = 1'b1;

      for (int t = 0; t < 4; t++) run_job(tv[t]);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               rv.a[i][j] = DW'($urandom_range(0, 65535));
               rv.b[i][j] = DW'($urandom_range(0, 65535));
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               sum = '0;
               for (int k = 0; k < N; k++)
                  sum = sum + ACC_W'(rv.a[i][k]) * ACC_W'(rv.b[k][j]);
               rv.exp[i][j] = sum;
            end
         rv.stall     = $urandom_range(0, 3);
         rv.ack_wait  = $urandom_range(0, 4);
         rv.hold      = 1'($urandom_range(0, 1));
         rv.ack_valid = 1'($urandom_range(0, 1));
         run_job(rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input skew stage upstream of the N×N output-stationary `P_Element` array. It accepts one k-slice per beat over a valid/ready handshake: column k of A and row k of B. It drives the west-edge and north-edge lanes with the diagonal skew the array needs, so A[i][k] and B[k][j] meet in PE[i][j]. It also sequences the matrix job: it clears the PE accumulators, flushes zeros until the last product has landed, and signals completion.

## Interface
- `N`, 4, array dimension; also the inner-product length (beats per job).
- `DW`, 16, operand width; matches PE `in_N`/`in_W`.
- `clk  input  1`  clock, rising edge.
- `reset  input  1`  asynchronous, active-low reset.
- `in_valid  input  1`  k-slice present.
- `in_ready  output  1`  slice accepted on an edge where `in_valid & in_ready`.
- `in_a  input  N*DW`  A[i][k] at bits `[i*DW +: DW]`.
- `in_b  input  N*DW`  B[k][j] at bits `[j*DW +: DW]`.
- `out_W  output  N*DW`  to west `in_W` of row i, lane i.
- `out_N  output  N*DW`  to north `in_N` of column j, lane j.
- `pe_clear  output  1`  active-high accumulator clear to all PE `reset` inputs.
- `done  output  1`  results in PE `out` are final.
- `done_ack  input  1`  consumer has read results.

## Operation
- **States:** IDLE, FEED, FLUSH, DONE.
  - **IDLE:** `in_ready=1`, `pe_clear=1`, lanes are zero.
    - An accepted beat counts as beat 0 and moves the FSM to FEED; `pe_clear` drops on that edge.
    - If N=1, that beat moves the FSM straight to FLUSH.
  - **FEED:** `in_ready=1`; a beat counter runs 0..N-1.
    - Acceptance of beat N-1 moves the FSM to FLUSH and loads the flush counter with 2N-1.
  - **FLUSH:** `in_ready=0`; zeros are shifted in; the counter decrements every edge.
    - When the counter reaches 1, the next edge moves the FSM to DONE.
  - **DONE:** `done=1`, `in_ready=0`, lanes are zero.
    - `done_ack` moves the FSM to IDLE, which re-asserts `pe_clear`.
- **Skew:** each lane i of A and each lane j of B has a delay line of i+1 and j+1 registers respectively (the output register is included).
  - Every edge shifts all lines in lockstep.
  - The input at stage 0 is the accepted operand, or zero when no beat is accepted.
- **Stall:** in FEED with `in_valid=0`, zeros enter all lanes simultaneously.
  - This is a uniform wavefront bubble, so alignment is preserved and each PE accumulates 0·0.
  - Stalls are legal and unbounded.
- **Width:** operands pass through unmodified, with no sign handling in this block. Accumulation width belongs to the PE (32 bits).
- **Boundary conditions:**
  - `in_valid` in FLUSH or DONE is ignored.
  - `done_ack` outside DONE is ignored.
  - If `done_ack` and `in_valid` arrive together in DONE, there is no acceptance that cycle; the beat is taken in IDLE next cycle.
- **Reset (any time, including mid-job):** state=IDLE, counters=0, every delay register=0.
  - Outputs: `in_ready=1`, `pe_clear=1`, `done=0`, `out_W=out_N=0`.

## Timing
- Lane latency: beat accepted at edge E appears on lane i of `out_W` (lane j of `out_N`) after edge E+i (E+j).
- The PE hop adds 1 cycle per PE, so A[i][k] and B[k][j] meet at PE[i][j] input after edge E_k+i+j. They are accumulated at edge E_k+i+j+1.
- Last beat at edge E_L: PE[N-1][N-1] accumulates at E_L+2N-1.
  - FLUSH spans 2N-1 edges, so `done` rises after E_L+2N-1, the same cycle the final result is visible.
- `done` and `pe_clear` are registered (state-decoded registers). `in_ready` is a combinational decode of state.
- Minimum job length with no stalls: N beats + (2N-1) flush cycles + 1 DONE cycle + 1 IDLE cycle.

## Structure
- **Shared package `systolic_pkg`:**
  - state enum (IDLE/FEED/FLUSH/DONE);
  - default `N` and `DW`;
  - lane-slice helper localparams;
  - `ACC_W`=32, shared with the PE.
- **Sub-module `skew_delay_line`** (params `DEPTH`, `DW`): shift register with async active-low clear.
  - Instantiated 2N times from a generate loop with `DEPTH`=lane+1.
- The FSM and counters live in `systolic_feeder`; the counters are $clog2(2N)-bit.

## Test plan
All scenarios use N=2, DW=16 with a 2×2 `P_Element` array attached.
1. **Reset:** assert reset mid-FEED → immediately `out_W=out_N=0`, `pe_clear=1`, `in_ready=1`, `done=0`.
2. **Back-to-back multiply:** A=[[1,2],[3,4]], B=[[5,6],[7,8]], beats {a=(1,3), b=(5,6)} then {a=(2,4), b=(7,8)}.
   - `out_W` lane1 = 3 one cycle after lane0 = 1.
   - `done` 3 cycles after the last beat.
   - PE outputs 19, 22, 43, 50.
3. **Stalled input:** same data with 3 idle cycles between beats → identical results; `done` 3 cycles after the last beat.
4. **Handshake:** `in_valid` held high through FLUSH/DONE → `in_ready=0` and nothing is accepted. `done` stays high for 5 cycles until `done_ack`, then IDLE with `pe_clear=1`.
5. **Simultaneous ack+valid:** `done_ack` and `in_valid` together in DONE → no acceptance that cycle; accepted the next cycle in IDLE.
6. **Second job:** A=I, B=[[9,8],[7,6]] after ack → results 9, 8, 7, 6, proving the clear between jobs.
